// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one main-memory line port between the I-cache and
// D-cache controllers. Round-robin on ties, one transaction per grant.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_valid/i_rw/i_addr/i_wr        I-cache request (held until i_ready)
//   i_rd/i_ready/i_err              I-cache read data, completion pulse, timeout flag
//   d_*                             same set for the D-cache
//   mem_valid/mem_rw/mem_addr/mem_wr  request to the memory controller
//   mem_rd/mem_ready                memory read data and one-cycle completion
//   grant                           one-hot owner ([0] = I, [1] = D), 00 when idle
//
// Optional: define MEM_ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES
// cycles without mem_ready; the winner then sees ready with err = 1 and rd = 0.
module mem_line_arbiter #(
    parameter int unsigned ADDR_W         = 28,
    parameter int unsigned LINE_W         = 256,
    parameter int unsigned TO_W           = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wr,
    output logic [LINE_W-1:0] i_rd,
    output logic              i_ready,
    output logic              i_err,
    input  logic              d_valid,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wr,
    output logic [LINE_W-1:0] d_rd,
    output logic              d_ready,
    output logic              d_err,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wr,
    input  logic [LINE_W-1:0] mem_rd,
    input  logic              mem_ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              last_d, last_d_nx;   // 1 = previous grant went to D
    logic              pick_d;
    logic [1:0]        grant_nx;
    logic              mem_valid_nx, mem_rw_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [LINE_W-1:0] mem_wr_nx, i_rd_nx, d_rd_nx;
    logic              i_ready_nx, d_ready_nx;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt, to_cnt_nx;
    logic              to_hit;
    logic              i_err_nx, d_err_nx;
`endif

    // Next-state and next-output logic; every registered output has a _nx here.
    always_comb begin
        state_nx     = state;
        last_d_nx    = last_d;
        grant_nx     = grant;
        mem_valid_nx = mem_valid;
        mem_rw_nx    = mem_rw;
        mem_addr_nx  = mem_addr;
        mem_wr_nx    = mem_wr;
        i_rd_nx      = i_rd;
        d_rd_nx      = d_rd;
        i_ready_nx   = 1'b0;
        d_ready_nx   = 1'b0;
        // D wins when it is alone, or on a tie when I was served last.
        pick_d       = d_valid && (!i_valid || !last_d);
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_nx    = to_cnt;
        to_hit       = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        i_err_nx     = 1'b0;
        d_err_nx     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (i_valid || d_valid) begin
                    state_nx     = S_GRANT;
                    last_d_nx    = pick_d;
                    grant_nx     = pick_d ? 2'b10 : 2'b01;
                    mem_valid_nx = 1'b1;
                    mem_rw_nx    = pick_d ? d_rw   : i_rw;
                    mem_addr_nx  = pick_d ? d_addr : i_addr;
                    mem_wr_nx    = pick_d ? d_wr   : i_wr;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_nx    = '0;
`endif
                end
            end
            S_GRANT: begin
                if (mem_ready) begin
                    state_nx     = S_DONE;
                    mem_valid_nx = 1'b0;
                    i_ready_nx   = grant[0];
                    d_ready_nx   = grant[1];
                    if (!mem_rw) begin
                        if (grant[1]) d_rd_nx = mem_rd;
                        else          i_rd_nx = mem_rd;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (to_hit) begin
                    state_nx     = S_DONE;
                    mem_valid_nx = 1'b0;
                    i_ready_nx   = grant[0];
                    d_ready_nx   = grant[1];
                    i_err_nx     = grant[0];
                    d_err_nx     = grant[1];
                    if (grant[1]) d_rd_nx = '0;
                    else          i_rd_nx = '0;
                end else begin
                    to_cnt_nx    = to_cnt + TO_W'(1);
`endif
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                grant_nx = 2'b00;
            end
            default: begin
                state_nx     = S_IDLE;
                grant_nx     = 2'b00;
                mem_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last_d    <= 1'b1;
            grant     <= 2'b00;
            mem_valid <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wr    <= '0;
            i_rd      <= '0;
            d_rd      <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state     <= state_nx;
            last_d    <= last_d_nx;
            grant     <= grant_nx;
            mem_valid <= mem_valid_nx;
            mem_rw    <= mem_rw_nx;
            mem_addr  <= mem_addr_nx;
            mem_wr    <= mem_wr_nx;
            i_rd      <= i_rd_nx;
            d_rd      <= d_rd_nx;
            i_ready   <= i_ready_nx;
            d_ready   <= d_ready_nx;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Grant-cycle counter and error flags for the abort path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            i_err  <= 1'b0;
            d_err  <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nx;
            i_err  <= i_err_nx;
            d_err  <= d_err_nx;
        end
    end
`else
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule
